// File: rtl/core_pkg.sv
// Definitions shared by the RV32I core control blocks: the hazard FSM states,
// well-known register numbers and the opcode constants used by decode.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [4:0]  REG_X17        = 5'd17;
    localparam logic [31:0] ECALL_HALT_VAL = 32'd10;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
// clr is synchronous and takes priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / redirect hazard control for the 5-stage pipe, plus the ecall
// drain-then-halt sequence and stall/flush performance counters.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | normal issue; hazards resolved by stall, bubble or flush
//   ST_DRAIN | halting ecall ahead in the pipe; older instructions retire
//   ST_HALT  | pipe empty, core halted until reset
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_ecall,
    input  logic             id_x17_is_ten,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          load_use, ecall_use;
    logic          stall_inc, flush_inc;

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

    assign ecall_use = id_is_ecall && ex_mem_read && (ex_rd == REG_X17);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (!reset) begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_redirect) begin
                        // ID holds a wrong-path instruction; its hazards are moot.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use || ecall_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                    end else if (id_is_ecall && id_x17_is_ten) begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_d     = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (drain_q == '0) begin
                        state_d = ST_HALT;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                ST_HALT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    halted       = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (reset),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (reset),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule
